// File: rtl/riscv_pkg.sv
// Shared core definitions: XLEN, M-extension multiply op codes and
// multiplier FSM encoding, plus small operand helpers.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MUL_H   = 2'b01,
        MUL_HSU = 2'b10,
        MUL_HU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_CALC = 2'b01,
        MS_FIX  = 2'b10,
        MS_DONE = 2'b11
    } mul_state_e;

    function automatic logic rs1_is_signed(mul_op_e op);
        return (op == MUL_H) || (op == MUL_HSU);
    endfunction

    function automatic logic rs2_is_signed(mul_op_e op);
        return (op == MUL_H);
    endfunction

    // 0x80000000 maps to itself, which is the correct unsigned magnitude
    function automatic logic [XLEN-1:0] magnitude(logic [XLEN-1:0] v,
                                                 logic             neg);
        return neg ? (~v + 1) : v;
    endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit groups with lookahead group carries,
// bit carries rippled inside each group from the group carry-in.
module cla32 (
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  gc;
    logic [31:0] bc;

    assign g = d1 & d2;
    assign p = d1 ^ d2;

    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        gc[0] = cin;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
    end

    always_comb begin
        bc = '0;
        for (int i = 0; i < 32; i++) begin
            if (i % 4 == 0) begin
                bc[i] = gc[i/4];
            end else begin
                bc[i] = g[i-1] | (p[i-1] & bc[i-1]);
            end
        end
    end

    assign sum  = p ^ bc;
    assign cout = gc[8];

endmodule

// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add RV32M multiplier: sign-magnitude operands,
// 32 add/shift cycles through cla32, one fix-up cycle for sign and select.
module mul_iter
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    mul_state_e state_q, state_d;

    logic [4:0]        count_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   mplr_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   result_q;
    logic              neg_q;
    mul_op_e           op_q;

    mul_op_e           op_in;
    logic              s1_neg;
    logic              s2_neg;
    logic [XLEN-1:0]   addend;
    logic [XLEN-1:0]   sum;
    logic              cout;
    logic [2*XLEN-1:0] prod;

    assign op_in  = mul_op_e'(op);
    assign s1_neg = rs1_is_signed(op_in) & rs1[XLEN-1];
    assign s2_neg = rs2_is_signed(op_in) & rs2[XLEN-1];
    assign addend = mplr_q[0] ? mcand_q : '0;

    cla32 u_cla (
        .d1   (hi_q),
        .d2   (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    assign prod = neg_q ? (~{hi_q, mplr_q} + 64'd1) : {hi_q, mplr_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MS_IDLE: if (in_valid) state_d = MS_CALC;
            MS_CALC: begin
                if (flush) begin
                    state_d = MS_IDLE;
                end else if (count_q == 5'd31) begin
                    state_d = MS_FIX;
                end
            end
            MS_FIX:  state_d = flush ? MS_IDLE : MS_DONE;
            MS_DONE: if (flush || out_ready) state_d = MS_IDLE;
            default: state_d = MS_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == MS_IDLE);
        busy      = (state_q != MS_IDLE);
        out_valid = (state_q == MS_DONE);
        result    = result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            hi_q     <= '0;
            neg_q    <= 1'b0;
            op_q     <= MUL_LO;
            result_q <= '0;
        end else begin
            unique case (state_q)
                MS_IDLE: begin
                    if (in_valid) begin
                        mcand_q <= magnitude(rs1, s1_neg);
                        mplr_q  <= magnitude(rs2, s2_neg);
                        neg_q   <= s1_neg ^ s2_neg;
                        op_q    <= op_in;
                        hi_q    <= '0;
                        count_q <= '0;
                    end
                end
                MS_CALC: begin
                    // 65-bit {cout, sum, mplr} logical shift right by one
                    if (!flush) begin
                        hi_q    <= {cout, sum[XLEN-1:1]};
                        mplr_q  <= {sum[0], mplr_q[XLEN-1:1]};
                        count_q <= count_q + 5'd1;
                    end
                end
                MS_FIX: begin
                    if (!flush) begin
                        result_q <= (op_q == MUL_LO) ? prod[XLEN-1:0]
                                                     : prod[2*XLEN-1:XLEN];
                    end
                end
                MS_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Directed and randomized checks of mul_iter against a 64-bit arithmetic
// reference model: results, latency, backpressure, flush and async reset.
module tb_mul_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    mul_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(logic [1:0] o, logic [31:0] a,
                                          logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (o == 2'd1 || o == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (o == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op; returns with the accept edge just passed (+1).
    task automatic accept(logic [1:0] o, logic [31:0] a, logic [31:0] b,
                          string tag);
        chk({tag, ".in_ready_pre"}, {63'd0, in_ready}, 64'd1);
        op       = o;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op       = 2'($urandom_range(0, 3));
        rs1      = $urandom;
        rs2      = $urandom;
    endtask

    // Cycle 1 is the one right after the accept edge.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 60) begin
            step();
            cyc++;
        end
    endtask

    task automatic run_op(logic [1:0] o, logic [31:0] a, logic [31:0] b,
                          int bp, string tag);
        int cyc;
        logic [31:0] exp;
        exp = model(o, a, b);
        out_ready = 1'b0;
        accept(o, a, b, tag);
        wait_valid(cyc);
        chk({tag, ".latency"}, 64'(cyc), 64'd34);
        chk({tag, ".result"}, {32'd0, result}, {32'd0, exp});
        for (int i = 0; i < bp; i++) begin
            step();
            chk({tag, ".hold"}, {29'd0, out_valid, in_ready, busy, result},
                {29'd0, 3'b101, exp});
        end
        out_ready = 1'b1;
        #1;
        chk({tag, ".hs_in_ready"}, {63'd0, in_ready}, 64'd0);
        step();
        out_ready = 1'b0;
        chk({tag, ".post_hs"}, {61'd0, out_valid, in_ready, busy},
            {61'd0, 3'b010});
    endtask

    initial begin
        int          cyc;
        int          seen;
        logic [31:0] pool [6];
        logic [31:0] a;
        logic [31:0] b;

        pool[0] = 32'h0000_0000;
        pool[1] = 32'h8000_0000;
        pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h7FFF_FFFF;
        pool[4] = 32'h0000_0001;
        pool[5] = 32'h8000_0001;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'd0;
        rs1       = '0;
        rs2       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("reset_outputs", {29'd0, in_ready, out_valid, busy, result},
            {29'd0, 3'b100, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'd0, 32'd7, 32'd6, 0, "mul_7x6");
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh_min");
        run_op(2'd0, 32'hFFFF_FFFF, 32'd5, 0, "mul_neg1x5");
        run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_ff");
        run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_ff");
        run_op(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5, "mulhu_bp");
        chk("mulhu_bp.const", {32'd0, model(2'd3, 32'h1234_5678,
            32'h9ABC_DEF0)}, 64'h0B00_EA4E);

        // flush at CALC count 10
        accept(2'd0, 32'd100, 32'd200, "flush");
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush.idle", {61'd0, in_ready, busy, out_valid},
            {61'd0, 3'b100});
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("flush.no_valid", 64'(seen), 64'd0);
        run_op(2'd0, 32'd3, 32'd4, 0, "mul_3x4");

        // flush together with out_ready in DONE discards the result
        accept(2'd1, 32'hDEAD_BEEF, 32'h1234_5678, "flush_done");
        wait_valid(cyc);
        chk("flush_done.latency", 64'(cyc), 64'd34);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("flush_done.idle", {61'd0, in_ready, busy, out_valid},
            {61'd0, 3'b100});

        // flush during accept in IDLE is ignored
        flush = 1'b1;
        accept(2'd3, 32'hCAFE_F00D, 32'h0BAD_F00D, "flush_idle");
        flush = 1'b0;
        chk("flush_idle.busy", {63'd0, busy}, 64'd1);
        wait_valid(cyc);
        chk("flush_idle.latency", 64'(cyc), 64'd34);
        chk("flush_idle.result", {32'd0, result},
            {32'd0, model(2'd3, 32'hCAFE_F00D, 32'h0BAD_F00D)});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // asynchronous reset mid-CALC
        accept(2'd0, 32'h1111_1111, 32'h2222_2222, "areset");
        for (int i = 0; i < 15; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.outputs", {29'd0, in_ready, out_valid, busy, result},
            {29'd0, 3'b100, 32'd0});
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("areset.no_stale", 64'(seen), 64'd0);
        run_op(2'd0, 32'h0000_FFFF, 32'h0000_FFFF, 0, "mul_ffff");

        // randomized ops with corner operands mixed in
        for (int t = 0; t < 24; t++) begin
            a = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)]
                                            : $urandom;
            b = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)]
                                            : $urandom;
            run_op(2'($urandom_range(0, 3)), a, b, $urandom_range(0, 3),
                   $sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_iter.md
Name: mul_iter

Overview:
- Multi-cycle RV32M multiplier in the execute stage.
- Consumes the core's 32-bit carry-lookahead adder as its only add engine: one partial-product add per cycle, radix-2 shift-add.
- Receives operands from decode/issue via a valid/ready handshake and returns a 32-bit result to writeback via a second valid/ready handshake.
- Supports MUL, MULH, MULHSU and MULHU.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- rs1  in  32  multiplicand operand.
- rs2  in  32  multiplier operand.
- flush  in  1  kill the in-flight operation (pipeline flush).
- out_valid  out  1  result is valid.
- out_ready  in  1  writeback accepts the result.
- result  out  32  MUL: product[31:0]; other ops: product[63:32].
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, result=0.
  - All datapath registers are cleared.
- States are IDLE, CALC, FIX and DONE.
- IDLE:
  - On in_valid & in_ready, capture the operands and go to CALC with count=0.
  - Signed-operand rule: rs1 is signed for MULH and MULHSU; rs2 is signed for MULH only.
  - Capture magnitudes only: mcand=|rs1| and mplr=|rs2|, each by the rule above.
  - neg = sign(rs1) XOR sign(rs2), counting only the operands that are signed.
  - Store op. Clear hi.
- CALC (exactly 32 cycles, count 0..31):
  - {c,s} = adder(hi, mplr[0] ? mcand : 0, cin=0).
  - Next {hi, mplr} = {c, s, mplr} >> 1, i.e. a 65-bit logical right shift.
  - When count==31, go to FIX.
- FIX (1 cycle):
  - P = {hi, mplr}.
  - If neg, P = ~P + 1 (64-bit two's complement).
  - Register result from P per op, then go to DONE.
- DONE:
  - out_valid=1; result holds stable while out_ready=0.
  - On out_ready, go to IDLE; in_ready rises the cycle after the handshake, never in the same cycle.
- Latency: out_valid asserts 34 cycles after the accepting edge. Latency is fixed; there is no early-out for zero operands.
- Magnitude of 0x80000000 is 0x80000000, taken as unsigned; this is correct because the magnitude is 33-bit-safe in the unsigned datapath.
- flush:
  - Synchronous; from CALC, FIX or DONE go to IDLE on the next edge.
  - out_valid drops on that edge, and no result handshake occurs for the killed op.
  - flush in IDLE is ignored.
  - flush together with an in_valid accept in IDLE: flush has no effect, and the op is accepted.
- flush and out_ready in the same DONE cycle: treated as flush; result is discarded, and the state still returns to IDLE.
- Reset mid-operation aborts immediately; no partial output appears after rst_n rises.
- Inputs other than in_valid, flush, out_ready and rst_n are don't-care outside IDLE.

Decomposition:
- Shared package (riscv_pkg) holds:
  - MUL op codes MUL_LO, MUL_H, MUL_HSU, MUL_HU.
  - State encoding for IDLE, CALC, FIX and DONE.
  - XLEN.
- Sub-module: one instance of the team's cla32 adder (d1=hi, d2=gated mcand, cin=0, sum→s, cout→c).
- The FIX negation uses behavioural arithmetic, not cla32.

Test Plan:
- MUL rs1=7, rs2=6, out_ready=1 → out_valid first high exactly 34 cycles after accept, result=0x0000002A, in_ready back high the following cycle.
- MULH rs1=0x80000000, rs2=0x80000000 → product 0x40000000_00000000 → result=0x40000000. Then MUL rs1=0xFFFFFFFF (-1), rs2=5 → result=0xFFFFFFFB.
- MULHSU rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF (unsigned) → product 0xFFFFFFFF_00000001 → result=0xFFFFFFFF. MULHU with the same operands → product 0xFFFFFFFE_00000001 → result=0xFFFFFFFE.
- Backpressure: MULHU 0x12345678×0x9ABCDEF0, out_ready=0 for 5 cycles after out_valid → result stays 0x0B00EA4E, in_ready=0 and busy=1 throughout; single handshake when out_ready=1.
- Flush: assert flush at CALC count 10 → IDLE next cycle, in_ready=1, out_valid never asserts. A following MUL 3×4 returns 12 with normal 34-cycle latency (no stale state).
- Reset: drop rst_n asynchronously in mid-CALC → outputs immediately show reset values (out_valid=0, result=0, in_ready=1). Release rst_n → an accepted MUL 0xFFFF×0xFFFF returns 0xFFFE0001.
